register_file: RTL and testbench

Architectural integer register file for the pipelined datapath: receives the Writeback-stage result (`W_rd`) on its write port and serves two combinational read ports to the Decode stage. After reset, a built-in clear sequencer zeroes x1..x31 one register per cycle and raises a busy flag so the hazard unit stalls fetch/decode until the file is clean. x0 is hardwired to zero. An optional write-through bypass lets Decode see a same-cycle Writeback value.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/rf_read_port.sv | 31 +++
 rtl/register_file.sv | 102 ++++++++++
 tb/tb_register_file.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared datapath constants and register-file FSM states.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = $clog2(REG_COUNT);

    localparam logic [REG_ADDR_W-1:0] RF_CLR_FIRST = REG_ADDR_W'(1);
    localparam logic [REG_ADDR_W-1:0] RF_CLR_LAST  = REG_ADDR_W'(REG_COUNT - 1);

    typedef enum logic {
        RF_INIT,
        RF_READY
    } rf_state_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port of the register file; x0 and busy force zero.
// With REGFILE_BYPASS_EN defined, a same-cycle Writeback to this address is forwarded (write-first).
module rf_read_port
    import riscv_pkg::*;
(
    input  logic [REG_ADDR_W-1:0]           addr_i,
    input  logic [REG_COUNT-1:0][XLEN-1:0]  regs_i,
    input  logic                            busy_i,
`ifdef REGFILE_BYPASS_EN
    input  logic                            byp_we_i,
    input  logic [REG_ADDR_W-1:0]           byp_addr_i,
    input  logic [XLEN-1:0]                 byp_data_i,
`endif
    output logic [XLEN-1:0]                 data_o
);

    always_comb begin
        if (busy_i || (addr_i == '0)) begin
            data_o = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (byp_we_i && (byp_addr_i == addr_i)) begin
            data_o = byp_data_i;
        end
`endif
        else begin
            data_o = regs_i[addr_i];
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file: clear sequencer after reset, one write port, two read ports.
// Optional write-through bypass on the read ports is enabled by defining REGFILE_BYPASS_EN.
module register_file
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  W_reg_write,
    input  logic [REG_ADDR_W-1:0] W_rd_addr,
    input  logic [XLEN-1:0]       W_rd,
    input  logic [REG_ADDR_W-1:0] D_rs1_addr,
    input  logic [REG_ADDR_W-1:0] D_rs2_addr,
    output logic [XLEN-1:0]       D_rs1_data,
    output logic [XLEN-1:0]       D_rs2_data,
    output logic                  rf_init_busy
);

    rf_state_t                     state_q, state_d;
    logic [REG_ADDR_W-1:0]         clr_idx_q, clr_idx_d;
    logic [REG_COUNT-1:0][XLEN-1:0] regs_q;

    logic                  wr_en;
    logic                  mem_we;
    logic [REG_ADDR_W-1:0] mem_waddr;
    logic [XLEN-1:0]       mem_wdata;

    assign wr_en        = (state_q == RF_READY) && W_reg_write && (W_rd_addr != '0);
    assign rf_init_busy = (state_q == RF_INIT);

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        mem_we    = 1'b0;
        mem_waddr = W_rd_addr;
        mem_wdata = W_rd;

        unique case (state_q)
            RF_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = clr_idx_q;
                mem_wdata = '0;
                if (clr_idx_q == RF_CLR_LAST) begin
                    state_d = RF_READY;
                end else begin
                    clr_idx_d = clr_idx_q + REG_ADDR_W'(1);
                end
            end
            RF_READY: begin
                mem_we = wr_en;
            end
            default: begin
                state_d = RF_INIT;
            end
        endcase

        // Reset wins over both the clear step and any Writeback write.
        if (rst) begin
            state_d   = RF_INIT;
            clr_idx_d = RF_CLR_FIRST;
            mem_we    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        state_q   <= state_d;
        clr_idx_q <= clr_idx_d;
    end

    // NOTE: the array has no reset; the clear sequencer zeroes it instead, keeping it a plain memory.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            regs_q[mem_waddr] <= mem_wdata;
        end
    end

    rf_read_port u_rs1 (
        .addr_i     (D_rs1_addr),
        .regs_i     (regs_q),
        .busy_i     (rf_init_busy),
`ifdef REGFILE_BYPASS_EN
        .byp_we_i   (wr_en),
        .byp_addr_i (W_rd_addr),
        .byp_data_i (W_rd),
`endif
        .data_o     (D_rs1_data)
    );

    rf_read_port u_rs2 (
        .addr_i     (D_rs2_addr),
        .regs_i     (regs_q),
        .busy_i     (rf_init_busy),
`ifdef REGFILE_BYPASS_EN
        .byp_we_i   (wr_en),
        .byp_addr_i (W_rd_addr),
        .byp_data_i (W_rd),
`endif
        .data_o     (D_rs2_data)
    );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file against a simple array/counter reference model.
// Expectations follow REGFILE_BYPASS_EN when the bench is compiled with it defined.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        W_reg_write;
    logic [4:0]  W_rd_addr;
    logic [31:0] W_rd;
    logic [4:0]  D_rs1_addr;
    logic [4:0]  D_rs2_addr;
    logic [31:0] D_rs1_data;
    logic [31:0] D_rs2_data;
    logic        rf_init_busy;

    int vecs = 0;
    int errs = 0;

    // Reference model: architectural contents plus cycles of clearing still to go.
    logic [31:0] mdl [32];
    int          clr_left = 31;

    register_file dut (
        .clk          (clk),
        .rst          (rst),
        .W_reg_write  (W_reg_write),
        .W_rd_addr    (W_rd_addr),
        .W_rd         (W_rd),
        .D_rs1_addr   (D_rs1_addr),
        .D_rs2_addr   (D_rs2_addr),
        .D_rs1_data   (D_rs1_data),
        .D_rs2_data   (D_rs2_data),
        .rf_init_busy (rf_init_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (clr_left > 0 || a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (W_reg_write && W_rd_addr == a) return W_rd;
`endif
        return mdl[a];
    endfunction

    function automatic logic exp_busy();
        return clr_left > 0;
    endfunction

    task automatic model_edge();
        if (rst) begin
            clr_left = 31;
            for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        end else if (clr_left > 0) begin
            clr_left--;
        end else if (W_reg_write && W_rd_addr != 5'd0) begin
            mdl[W_rd_addr] = W_rd;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic r, input logic we, input logic [4:0] rd,
                         input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        rst         = r;
        W_reg_write = we;
        W_rd_addr   = rd;
        W_rd        = wd;
        D_rs1_addr  = a1;
        D_rs2_addr  = a2;
        #1;
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
        drive(1'b0, 1'b0, 5'd0, 32'h0, a1, a2);
    endtask

    task automatic fill_random();
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 1'b1, 5'(i), $urandom, 5'd0, 5'd0);
            tick();
        end
    endtask

    task automatic run_clear_checked(input string tag);
        for (int c = 0; c < 40; c++) begin
            idle(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            vecs++;
            if (rf_init_busy !== exp_busy()) begin
                errs++;
                $display("FAIL %s busy cycle %0d: got %b exp %b", tag, c, rf_init_busy, exp_busy());
            end
            vecs++;
            if (D_rs1_data !== exp_rd(D_rs1_addr) || D_rs2_data !== exp_rd(D_rs2_addr)) begin
                errs++;
                $display("FAIL %s read during clear cycle %0d: got %h/%h exp %h/%h", tag, c,
                         D_rs1_data, D_rs2_data, exp_rd(D_rs1_addr), exp_rd(D_rs2_addr));
            end
            if (!exp_busy()) break;
            tick();
        end
    endtask

    task automatic sweep_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            idle(5'(i), 5'(31 - i));
            vecs++;
            if (D_rs1_data !== 32'h0 || D_rs2_data !== 32'h0) begin
                errs++;
                $display("FAIL %s x%0d/x%0d: got %h/%h exp 0/0", tag, i, 31 - i, D_rs1_data, D_rs2_data);
            end
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        tick();
        idle(5'd1, 5'd2);
        vecs++;
        if (rf_init_busy !== 1'b1 || D_rs1_data !== 32'h0 || D_rs2_data !== 32'h0) begin
            errs++;
            $display("FAIL reset_values: got busy=%b %h/%h exp busy=1 0/0", rf_init_busy, D_rs1_data, D_rs2_data);
        end
        run_clear_checked("reset1");
        fill_random();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        tick();
        run_clear_checked("reset2");
        sweep_zero("after_clear");
    endtask

    task automatic test_write_read();
        drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2);
        tick();
        idle(5'd5, 5'd5);
        vecs++;
        if (D_rs1_data !== 32'hDEADBEEF) begin
            errs++;
            $display("FAIL write_x5: got %h exp %h", D_rs1_data, 32'hDEADBEEF);
        end
        drive(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
        tick();
        idle(5'd0, 5'd0);
        vecs++;
        if (D_rs1_data !== 32'h0 || D_rs2_data !== 32'h0) begin
            errs++;
            $display("FAIL write_x0: got %h/%h exp 0/0", D_rs1_data, D_rs2_data);
        end
    endtask

    task automatic test_same_cycle();
        drive(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd0, 5'd7);
        vecs++;
`ifdef REGFILE_BYPASS_EN
        if (D_rs2_data !== 32'hA5A5A5A5) begin
            errs++;
            $display("FAIL same_cycle_bypass: got %h exp %h", D_rs2_data, 32'hA5A5A5A5);
        end
`else
        if (D_rs2_data !== 32'h0) begin
            errs++;
            $display("FAIL same_cycle_old: got %h exp %h", D_rs2_data, 32'h0);
        end
`endif
        tick();
        idle(5'd0, 5'd7);
        vecs++;
        if (D_rs2_data !== 32'hA5A5A5A5) begin
            errs++;
            $display("FAIL same_cycle_next: got %h exp %h", D_rs2_data, 32'hA5A5A5A5);
        end
    endtask

    task automatic test_both_ports();
        drive(1'b0, 1'b1, 5'd9, 32'h00000042, 5'd0, 5'd0);
        tick();
        idle(5'd0, 5'd9);
        vecs++;
        if (D_rs2_data !== 32'h00000042 || D_rs1_data !== 32'h0) begin
            errs++;
            $display("FAIL both_ports: got rs1=%h rs2=%h exp rs1=0 rs2=42", D_rs1_data, D_rs2_data);
        end
        idle(5'd9, 5'd9);
        vecs++;
        if (D_rs1_data !== 32'h00000042 || D_rs2_data !== 32'h00000042) begin
            errs++;
            $display("FAIL same_addr: got %h/%h exp 42/42", D_rs1_data, D_rs2_data);
        end
    endtask

    task automatic test_init_write_ignored();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        tick();
        for (int c = 0; c < 31; c++) begin
            if (c == 10) drive(1'b0, 1'b1, 5'd3, 32'hFFFFFFFF, 5'd3, 5'd3);
            else         idle(5'd3, 5'd3);
            tick();
        end
        idle(5'd3, 5'd3);
        vecs++;
        if (rf_init_busy !== 1'b0 || D_rs1_data !== 32'h0) begin
            errs++;
            $display("FAIL init_write: got busy=%b x3=%h exp busy=0 x3=0", rf_init_busy, D_rs1_data);
        end
    endtask

    task automatic test_reset_mid_clear();
        fill_random();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        tick();
        for (int c = 0; c < 15; c++) begin
            idle(5'd0, 5'd0);
            tick();
        end
        drive(1'b1, 1'b1, 5'd4, 32'h5555AAAA, 5'd0, 5'd0);
        tick();
        run_clear_checked("mid_clear");
        sweep_zero("mid_clear_sweep");
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 99) == 0), $urandom_range(0, 1), 5'($urandom_range(0, 31)),
                  $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) begin
                D_rs1_addr = W_rd_addr;
                #1;
            end
            vecs++;
            if (D_rs1_data !== exp_rd(D_rs1_addr) || D_rs2_data !== exp_rd(D_rs2_addr) ||
                rf_init_busy !== exp_busy()) begin
                errs++;
                $display("FAIL random[%0d] a=%0d/%0d: got %h/%h busy=%b exp %h/%h busy=%b", n,
                         D_rs1_addr, D_rs2_addr, D_rs1_data, D_rs2_data, rf_init_busy,
                         exp_rd(D_rs1_addr), exp_rd(D_rs2_addr), exp_busy());
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        idle(5'd0, 5'd0);
        test_reset();
        test_write_read();
        test_same_cycle();
        test_both_ports();
        test_init_write_ignored();
        test_reset_mid_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
